// File: rtl/vga_timing_dither.sv
// vga_timing_dither: raster counters, latency-aligned sync and ordered-dither colour reduction
module vga_timing_dither #(
  parameter int H_DISPLAY  = 1220,
  parameter int H_FRONT    = 31,
  parameter int H_SYNC     = 183,
  parameter int H_BACK     = 91,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int IN_BITS    = 6,
  parameter int OUT_BITS   = 2,
  parameter int IN_LATENCY = 0,
  parameter int FRAME_BITS = 11,
  parameter int TEMPORAL   = 1
) (
  input  logic                  clk48,
  input  logic                  rst_n,
  input  logic                  frame_restart,
  input  logic                  blank_force,
  input  logic [IN_BITS-1:0]    r_in,
  input  logic [IN_BITS-1:0]    g_in,
  input  logic [IN_BITS-1:0]    b_in,
  output logic [10:0]           h_count,
  output logic [9:0]            v_count,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  line_end,
  output logic                  frame_end,
  output logic                  active,
  output logic                  hsync,
  output logic                  vsync,
  output logic [OUT_BITS-1:0]   r_out,
  output logic [OUT_BITS-1:0]   g_out,
  output logic [OUT_BITS-1:0]   b_out
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_DISPLAY);
  localparam logic [9:0]  VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam int DW = IN_BITS + OUT_BITS + 1;
  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);
  localparam logic TEMP_EN = TEMPORAL != 0;
  logic [10:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic hs_raw, vs_raw;
  logic [2:0] bx_i, bx_x;
  logic [4:0] b5;
  logic [8:0] st_in, st_out;
  logic hsync_q, hsync_d, vsync_q, vsync_d, show;
  logic [OUT_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  // Worst case sum stays below 2^(IN_BITS+OUT_BITS), so the cast drops only zero bits.
  function automatic logic [OUT_BITS-1:0] dither(input logic [IN_BITS-1:0] c, input logic [4:0] t);
    logic [DW-1:0] s;
    s = DW'(c) * DW'(2 ** OUT_BITS - 1) + (DW'(t) << (IN_BITS - 5));
    return OUT_BITS'(s >> IN_BITS);
  endfunction
  always_comb begin
    line_end = h_q == H_LAST;
    frame_end = line_end && v_q == V_LAST;
    active = h_q < H_ACT && v_q < V_ACT;
    hs_raw = h_q >= HS_BEG && h_q < HS_END;
    vs_raw = v_q >= VS_BEG && v_q < VS_END;
    h_d = line_end ? '0 : h_q + 11'd1;
    v_d = line_end ? (frame_end ? '0 : v_q + 10'd1) : v_q;
    frame_d = frame_end ? (frame_restart ? '0 : frame_q + FRAME_BITS'(1)) : frame_q;
    bx_i = h_q[2:0] ^ {3{frame_q[0] & TEMP_EN}};
    bx_x = bx_i ^ {1'b0, v_q[1:0]};
    b5 = {bx_x[0], bx_i[0], bx_x[1], bx_i[1], bx_x[2]};
    st_in = {hs_raw, vs_raw, active, blank_force, b5};
    show = st_out[6] & ~st_out[5];
    hsync_d = st_out[8] ? HS_ON : ~HS_ON;
    vsync_d = st_out[7] ? VS_ON : ~VS_ON;
    r_d = show ? dither(r_in, st_out[4:0]) : '0;
    g_d = show ? dither(g_in, st_out[4:0]) : '0;
    b_d = show ? dither(b_in, st_out[4:0]) : '0;
  end
  // Control word delay matches the effect pipeline feeding r/g/b_in.
  generate
    if (IN_LATENCY == 0) begin : g_direct
      assign st_out = st_in;
    end else begin : g_pipe
      logic [8:0] pipe_q [IN_LATENCY];
      always_ff @(posedge clk48 or negedge rst_n)
        if (!rst_n) for (int n = 0; n < IN_LATENCY; n++) pipe_q[n] <= '0;
        else begin
          pipe_q[0] <= st_in;
          for (int n = 1; n < IN_LATENCY; n++) pipe_q[n] <= pipe_q[n-1];
        end
      assign st_out = pipe_q[IN_LATENCY-1];
    end
  endgenerate
  always_ff @(posedge clk48 or negedge rst_n)
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
      frame_q <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      frame_q <= frame_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  assign h_count = h_q;
  assign v_count = v_q;
  assign frame = frame_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign r_out = r_q;
  assign g_out = g_q;
  assign b_out = b_q;
endmodule
